// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Staged reset release after power-on or a soft restart. A 2-flop synchronizer
// retimes the deassertion of reset_n. A counter then runs from 0 to GATE_END.
// A clock-gate enable window and per-channel reset releases are decoded from
// that count. Channel i is released once the count reaches
// REL_BASE + i*REL_STEP, and stays released until the next restart.
//
// Ports
//   clk              : single clock
//   reset_n          : asynchronous active-low reset, deassertion synchronized
//   soft_rst_req_i   : synchronous restart request (holds the sequence in RST)
//   gate_clk_o       : clock-gate enable, GATE_START <= cnt < GATE_END in COUNT
//   release_reset_o  : per-channel reset release, 1 = released
//   seq_busy_o       : high while counting
//   seq_done_o       : high once the sequence has completed
// -----------------------------------------------------------------------------
module reset_sequencer #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 6,
   parameter int GATE_START = 4,
   parameter int GATE_END   = 18,
   parameter int REL_BASE   = 10,
   parameter int REL_STEP   = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              soft_rst_req_i,
   output logic              gate_clk_o,
   output logic [NUM_CH-1:0] release_reset_o,
   output logic              seq_busy_o,
   output logic              seq_done_o
);

   if ((NUM_CH < 1) || (NUM_CH > 8) ||
       !(GATE_START < REL_BASE) ||
       !(REL_BASE + (NUM_CH - 1) * REL_STEP < GATE_END) ||
       !(GATE_END < (1 << CNT_W))) begin : g_bad_params
      $error("reset_sequencer: illegal parameter combination");
   end

   localparam logic [CNT_W-1:0] GATE_START_C = CNT_W'(GATE_START);
   localparam logic [CNT_W-1:0] GATE_END_C   = CNT_W'(GATE_END);
   localparam logic [CNT_W-1:0] GATE_LAST_C  = CNT_W'(GATE_END - 1);

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       sync_q;
   logic             rst_released;

   function automatic logic [CNT_W-1:0] rel_thr(input int idx);
      return CNT_W'(REL_BASE + idx * REL_STEP);
   endfunction

   // Output decode, packed as {gate, busy, done, release[NUM_CH-1:0]}.
   // It is applied to the *next* state/count so the registered outputs always
   // match the state/count registered on the same edge.
   function automatic logic [NUM_CH+2:0] decode(input state_t s,
                                                input logic [CNT_W-1:0] c);
      logic [NUM_CH-1:0] rel;
      logic              gate;
      rel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         rel[i] = (s != ST_RST) && (c >= rel_thr(i));
      end
      gate = (s == ST_COUNT) && (c >= GATE_START_C) && (c < GATE_END_C);
      return {gate, (s == ST_COUNT), (s == ST_DONE), rel};
   endfunction

   // Deassertion synchronizer; clears immediately when reset_n drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign rst_released = sync_q[1];

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RST;
         cnt_q   <= '0;
         {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <= '0;
      end else if (soft_rst_req_i) begin
         // A held request keeps the sequence parked in RST.
         state_q <= ST_RST;
         cnt_q   <= '0;
         {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <= '0;
      end else begin
         case (state_q)
            ST_RST: begin
               if (rst_released) begin
                  state_q <= ST_COUNT;
                  cnt_q   <= '0;
                  {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <=
                     decode(ST_COUNT, '0);
               end
            end
            ST_COUNT: begin
               if (cnt_q == GATE_LAST_C) begin
                  state_q <= ST_DONE;
                  cnt_q   <= GATE_END_C;
                  {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <=
                     decode(ST_DONE, GATE_END_C);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <=
                     decode(ST_COUNT, cnt_q + 1'b1);
               end
            end
            ST_DONE: begin
               // Terminal: count parks at GATE_END, no wrap.
               cnt_q <= GATE_END_C;
               {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <=
                  decode(ST_DONE, GATE_END_C);
            end
            default: begin
               state_q <= ST_RST;
               cnt_q   <= '0;
               {gate_clk_o, seq_busy_o, seq_done_o, release_reset_o} <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Two instances: A uses default parameters, B uses the minimal legal set
// (NUM_CH=1, GATE_END=11). B never sees a soft request, only reset_n.
// Outputs are sampled on the falling edge. Outputs observed after rising edge
// k correspond to sequence time t = k - 3 counted from the edge at which
// reset_n was released (t < 0 : RST, t in 0..GATE_END-1 : COUNT, else DONE).
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int CLK_P = 10;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       soft_rst_req_i = 1'b0;
   logic       soft_b = 1'b0;

   logic       gate_a, busy_a, done_a;
   logic [3:0] rel_a;
   logic       gate_b, busy_b, done_b;
   logic [0:0] rel_b;
   logic [6:0] out_a, out_b;

   int         n_total = 0;
   int         n_pass  = 0;
   int         t_a, t_b;
   logic [6:0] exp_a_q[$];
   logic [6:0] exp_b_q[$];

   logic       mon_en   = 1'b0;
   logic [3:0] prev_rel = 4'd0;

   always #(CLK_P/2) clk = ~clk;

   assign out_a = {gate_a, busy_a, done_a, rel_a};
   assign out_b = {gate_b, busy_b, done_b, 3'b000, rel_b};

   reset_sequencer dut_a (
      .clk            (clk),
      .reset_n        (reset_n),
      .soft_rst_req_i (soft_rst_req_i),
      .gate_clk_o     (gate_a),
      .release_reset_o(rel_a),
      .seq_busy_o     (busy_a),
      .seq_done_o     (done_a)
   );

   reset_sequencer #(
      .NUM_CH  (1),
      .GATE_END(11)
   ) dut_b (
      .clk            (clk),
      .reset_n        (reset_n),
      .soft_rst_req_i (soft_b),
      .gate_clk_o     (gate_b),
      .release_reset_o(rel_b),
      .seq_busy_o     (busy_b),
      .seq_done_o     (done_b)
   );

   // Expected {gate, busy, done, rel[3:0]} at sequence time t.
   // Gate window starts at 4; channel i releases at 10 + 2*i.
   function automatic logic [6:0] seq_exp(input int t, input int gend, input int nch);
      logic [3:0] rel;
      logic       gate, busy, done;
      int         c;
      rel = '0; gate = 1'b0; busy = 1'b0; done = 1'b0;
      if (t >= 0) begin
         c    = (t < gend) ? t : gend;
         busy = (t < gend);
         done = !busy;
         gate = busy && (c >= 4);
         for (int i = 0; i < nch; i++) rel[i] = (c >= 10 + 2 * i);
      end
      return {gate, busy, done, rel};
   endfunction

   // Invariants checked every cycle on instance A.
   always @(negedge clk) begin
      if (mon_en) begin
         n_total++;
         if ((busy_a && done_a) || (gate_a && !busy_a) ||
             (((prev_rel & ~rel_a) != 4'd0) && (busy_a || done_a)))
            $display("FAIL invariant busy=%b done=%b gate=%b rel=%b prev_rel=%b",
                     busy_a, done_a, gate_a, rel_a, prev_rel);
         else
            n_pass++;
         prev_rel = rel_a;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      logic [6:0] got, want;
      int gate_cnt, first_busy, first_gate, first_rel0, first_rel3, first_done;
      soft_rst_req_i = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (out_a !== 7'd0) $display("FAIL reset_hold_a got=%b want=%b", out_a, 7'd0);
      else n_pass++;
      n_total++;
      if (out_b !== 7'd0) $display("FAIL reset_hold_b got=%b want=%b", out_b, 7'd0);
      else n_pass++;
      @(posedge clk);              // edge 0
      #1 reset_n = 1'b1;
      mon_en = 1'b1;
      t_a = -3; t_b = -3;
      gate_cnt = 0; first_busy = -1; first_gate = -1;
      first_rel0 = -1; first_rel3 = -1; first_done = -1;
      for (int k = 1; k <= 30; k++) begin
         t_a++; t_b++;
         exp_a_q.push_back(seq_exp(t_a, 18, 4));
         exp_b_q.push_back(seq_exp(t_b, 11, 1));
         @(posedge clk);
         @(negedge clk);
         got = out_a; want = exp_a_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL reset_seq_a k=%0d got=%b want=%b", k, got, want);
         else n_pass++;
         got = out_b; want = exp_b_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL reset_seq_b k=%0d got=%b want=%b", k, got, want);
         else n_pass++;
         if (gate_a) gate_cnt++;
         if (busy_a && first_busy < 0) first_busy = k;
         if (gate_a && first_gate < 0) first_gate = k;
         if (rel_a[0] && first_rel0 < 0) first_rel0 = k;
         if (rel_a[3] && first_rel3 < 0) first_rel3 = k;
         if (done_a && first_done < 0) first_done = k;
      end
      n_total++;
      if (first_busy != 3) $display("FAIL first_busy got=%0d want=3", first_busy); else n_pass++;
      n_total++;
      if (first_gate != 7) $display("FAIL first_gate got=%0d want=7", first_gate); else n_pass++;
      n_total++;
      if (gate_cnt != 14) $display("FAIL gate_cycles got=%0d want=14", gate_cnt); else n_pass++;
      n_total++;
      if (first_rel0 != 13) $display("FAIL first_rel0 got=%0d want=13", first_rel0); else n_pass++;
      n_total++;
      if (first_rel3 != 19) $display("FAIL first_rel3 got=%0d want=19", first_rel3); else n_pass++;
      n_total++;
      if (first_done != 21) $display("FAIL first_done got=%0d want=21", first_done); else n_pass++;
   endtask

   task automatic test_soft_done();
      logic [6:0] got, want;
      int first_gate, first_done;
      first_gate = -1; first_done = -1;
      for (int n = 0; n < 30; n++) begin
         soft_rst_req_i = (n == 0);
         t_a = soft_rst_req_i ? -1 : t_a + 1;
         t_b++;
         exp_a_q.push_back(seq_exp(t_a, 18, 4));
         exp_b_q.push_back(seq_exp(t_b, 11, 1));
         @(posedge clk);
         @(negedge clk);
         got = out_a; want = exp_a_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL soft_done_a n=%0d got=%b want=%b", n, got, want);
         else n_pass++;
         got = out_b; want = exp_b_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL soft_done_b n=%0d got=%b want=%b", n, got, want);
         else n_pass++;
         if (gate_a && first_gate < 0) first_gate = n;
         if (done_a && first_done < 0) first_done = n;
      end
      soft_rst_req_i = 1'b0;
      n_total++;
      if (first_gate != 5) $display("FAIL soft_done_gate got=%0d want=5", first_gate); else n_pass++;
      n_total++;
      if (first_done != 19) $display("FAIL soft_done_done got=%0d want=19", first_done); else n_pass++;
   endtask

   task automatic test_soft_hold();
      logic [6:0] got, want;
      int zero_cnt, restart_n;
      zero_cnt = 0; restart_n = -1;
      for (int n = 0; n < 41; n++) begin
         // n=0 restarts from DONE; n=13 observes cnt 12; n=14..18 hold request.
         soft_rst_req_i = (n == 0) || (n >= 14 && n <= 18);
         t_a = soft_rst_req_i ? -1 : t_a + 1;
         t_b++;
         exp_a_q.push_back(seq_exp(t_a, 18, 4));
         exp_b_q.push_back(seq_exp(t_b, 11, 1));
         @(posedge clk);
         @(negedge clk);
         got = out_a; want = exp_a_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL soft_hold_a n=%0d got=%b want=%b", n, got, want);
         else n_pass++;
         got = out_b; want = exp_b_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL soft_hold_b n=%0d got=%b want=%b", n, got, want);
         else n_pass++;
         if (n >= 14 && n <= 18 && out_a == 7'd0) zero_cnt++;
         if (n > 18 && busy_a && restart_n < 0) restart_n = n;
      end
      soft_rst_req_i = 1'b0;
      n_total++;
      if (zero_cnt != 5) $display("FAIL soft_hold_zero got=%0d want=5", zero_cnt); else n_pass++;
      n_total++;
      if (restart_n != 19) $display("FAIL soft_hold_restart got=%0d want=19", restart_n); else n_pass++;
   endtask

   task automatic test_async_reset();
      logic [6:0] got, want;
      for (int n = 0; n < 17; n++) begin
         soft_rst_req_i = (n == 0);
         t_a = soft_rst_req_i ? -1 : t_a + 1;
         t_b++;
         exp_a_q.push_back(seq_exp(t_a, 18, 4));
         exp_b_q.push_back(seq_exp(t_b, 11, 1));
         @(posedge clk);
         @(negedge clk);
         got = out_a; want = exp_a_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL async_pre_a n=%0d got=%b want=%b", n, got, want);
         else n_pass++;
         got = out_b; want = exp_b_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL async_pre_b n=%0d got=%b want=%b", n, got, want);
         else n_pass++;
      end
      soft_rst_req_i = 1'b0;
      // cnt is 15 on A here; drop reset between edges
      #2 reset_n = 1'b0;
      #1;
      n_total++;
      if (out_a !== 7'd0) $display("FAIL async_immediate_a got=%b want=%b", out_a, 7'd0);
      else n_pass++;
      n_total++;
      if (out_b !== 7'd0) $display("FAIL async_immediate_b got=%b want=%b", out_b, 7'd0);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_total++;
      if (out_a !== 7'd0) $display("FAIL async_held_a got=%b want=%b", out_a, 7'd0);
      else n_pass++;
      @(posedge clk);              // edge 0
      #1 reset_n = 1'b1;
      t_a = -3; t_b = -3;
      for (int k = 1; k <= 25; k++) begin
         t_a++; t_b++;
         exp_a_q.push_back(seq_exp(t_a, 18, 4));
         exp_b_q.push_back(seq_exp(t_b, 11, 1));
         @(posedge clk);
         @(negedge clk);
         got = out_a; want = exp_a_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL async_restart_a k=%0d got=%b want=%b", k, got, want);
         else n_pass++;
         got = out_b; want = exp_b_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL async_restart_b k=%0d got=%b want=%b", k, got, want);
         else n_pass++;
      end
   endtask

   task automatic test_minimal();
      logic [6:0] got, want;
      int first_rel0, first_done, static_cnt;
      first_rel0 = -1; first_done = -1; static_cnt = 0;
      reset_n = 1'b0;
      @(posedge clk);              // edge 0, still in reset
      #1 reset_n = 1'b1;
      t_a = -3; t_b = -3;
      for (int k = 1; k <= 115; k++) begin
         t_a++; t_b++;
         exp_a_q.push_back(seq_exp(t_a, 18, 4));
         exp_b_q.push_back(seq_exp(t_b, 11, 1));
         @(posedge clk);
         @(negedge clk);
         got = out_a; want = exp_a_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL minimal_a k=%0d got=%b want=%b", k, got, want);
         else n_pass++;
         got = out_b; want = exp_b_q.pop_front();
         n_total++;
         if (got !== want) $display("FAIL minimal_b k=%0d got=%b want=%b", k, got, want);
         else n_pass++;
         if (rel_b[0] && first_rel0 < 0) first_rel0 = k;
         if (done_b && first_done < 0) first_done = k;
         if (first_done > 0 && out_b === 7'b0010001) static_cnt++;
      end
      n_total++;
      if (first_rel0 != 13) $display("FAIL minimal_rel0 got=%0d want=13", first_rel0); else n_pass++;
      n_total++;
      if (first_done - first_rel0 != 1)
         $display("FAIL minimal_rel_to_done got=%0d want=1", first_done - first_rel0);
      else n_pass++;
      n_total++;
      if (static_cnt < 100) $display("FAIL minimal_static got=%0d want>=100", static_cnt);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_soft_done();
      test_soft_hold();
      test_async_reset();
      test_minimal();
      mon_en = 1'b0;
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Parameters
REQ-001 SHALL have parameter NUM_CH, default 4: number of downstream reset channels, range 1..8.
REQ-002 SHALL have parameter CNT_W, default 6: sequence counter width.
REQ-003 SHALL have parameter GATE_START, default 4: first count value with clock gate enabled.
REQ-004 SHALL have parameter GATE_END, default 18: terminal count; clock gate is off from this value.
REQ-005 SHALL have parameter REL_BASE, default 10: release count for channel 0.
REQ-006 SHALL have parameter REL_STEP, default 2: release count increment per channel index.
REQ-007 SHALL require GATE_START < REL_BASE, REL_BASE+(NUM_CH-1)*REL_STEP < GATE_END, and GATE_END < 2^CNT_W; violation is an elaboration-time error.

Interface
REQ-008 SHALL have clk, input, 1: single clock.
REQ-009 SHALL have reset_n, input, 1: asynchronous active-low reset.
REQ-010 SHALL have soft_rst_req_i, input, 1: synchronous request to restart the sequence.
REQ-011 SHALL have gate_clk_o, output, 1: clock-gate enable during the gating window.
REQ-012 SHALL have release_reset_o, output, NUM_CH: per-channel reset release, 1 = released.
REQ-013 SHALL have seq_busy_o, output, 1: high while counting.
REQ-014 SHALL have seq_done_o, output, 1: high when the sequence is complete.

Function
REQ-015 SHALL pass reset_n deassertion through a 2-flop synchronizer that clears asynchronously; synced reset is high from the 2nd rising edge after deassertion.
REQ-016 SHALL implement FSM states RST, COUNT and DONE, plus a CNT_W-bit counter cnt_q.
REQ-017 SHALL move RST->COUNT at an edge where synced reset=1 and soft_rst_req_i=0, with cnt_q=0.
REQ-018 SHALL, in COUNT, increment cnt_q by 1 each edge; at the edge where cnt_q==GATE_END-1, cnt_q becomes GATE_END and state becomes DONE.
REQ-019 SHALL, in DONE, hold cnt_q=GATE_END indefinitely; no wrap-around.
REQ-020 SHALL, when soft_rst_req_i=1 at an edge in COUNT or DONE, go to RST with cnt_q=0; while soft_rst_req_i is held high, state stays RST.
REQ-021 SHALL drive all outputs from flops, each equal in every cycle to the decode of the current state and cnt_q; no combinational path from inputs to outputs.
REQ-022 SHALL decode gate_clk_o = (state==COUNT) and GATE_START <= cnt_q < GATE_END.
REQ-023 SHALL decode release_reset_o[i] = (state!=RST) and cnt_q >= REL_BASE + i*REL_STEP.
REQ-024 SHALL decode seq_busy_o = (state==COUNT) and seq_done_o = (state==DONE); the two are never high together.
REQ-025 SHALL compare cnt_q against the parameter thresholds at CNT_W width with unsigned arithmetic.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force state=RST, cnt_q=0, synchronizer=0 and every output=0, including mid-sequence.
REQ-027 SHALL restart the full sequence, synchronizer latency included, on each reset_n deassertion.

Verification
REQ-028 Defaults, reset_n rises before edge 0 -> COUNT after edge 3; gate_clk_o high after edges 7..20 (14 cycles); release[0] after edge 13, release[3] after edge 19; seq_done_o after edge 21.
REQ-029 soft_rst_req_i pulsed 1 cycle in DONE -> next cycle all outputs 0; COUNT with cnt_q=0 one edge later; sequence repeats with identical timing.
REQ-030 soft_rst_req_i held 5 cycles during COUNT at cnt_q=12 -> outputs 0 for 5 cycles; counting restarts from 0 at the first edge with the request low.
REQ-031 reset_n pulsed low mid-edge-interval at cnt_q=15 -> all outputs 0 immediately (no clock); full sequence restarts after 2-edge sync.
REQ-032 NUM_CH=1, GATE_END=GATE_START+REL_BASE-GATE_START+1 minimal legal set -> release[0] high exactly 1 cycle before seq_done_o; outputs hold static in DONE for 100 cycles.
REQ-033 Continuous checks -> seq_busy_o and seq_done_o never both high; release bits monotonic within one sequence; gate_clk_o never high in RST or DONE.
